// File: rtl/control_pkg.sv
// Shared types and encodings for the multicycle accumulator controller.
// Holds the FSM state enum, opcode numbers, datapath mux selects and the control bundle.
package control_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_ALUI, S_STORE, S_MEMRD, S_ALUM, S_JAL,
    S_BRANCH, S_SPC2, S_LWA1, S_LWA2, S_ILLEGAL, S_HALT
  } state_e;

  localparam int OPC_ADDI = 0;
  localparam int OPC_SW   = 8;
  localparam int OPC_OR   = 11;
  localparam int OPC_JAL  = 13;
  localparam int OPC_BR   = 15;
  localparam int OPC_SPC  = 22;
  localparam int OPC_LWA  = 23;

  localparam logic [1:0] ALU_A_PC     = 2'b00;
  localparam logic [1:0] ALU_A_SP     = 2'b01;
  localparam logic [1:0] ALU_A_ACC    = 2'b10;
  localparam logic [1:0] ALU_B_IR     = 2'b00;
  localparam logic [1:0] ALU_B_IMM    = 2'b01;
  localparam logic [1:0] ALU_B_ONE    = 2'b10;
  localparam logic [1:0] ALU_B_MEM    = 2'b11;
  localparam logic [1:0] PC_SRC_ALUO  = 2'b00;
  localparam logic [1:0] PC_SRC_INC   = 2'b01;
  localparam logic [1:0] PC_SRC_BR    = 2'b10;
  localparam logic [1:0] ACC_SRC_ALU  = 2'b00;
  localparam logic [1:0] ACC_SRC_MEM  = 2'b10;
  localparam logic [1:0] MEM_ADDR_PC  = 2'b00;
  localparam logic [1:0] MEM_ADDR_ALU = 2'b01;
  localparam logic [1:0] MEM_ADDR_SP  = 2'b10;
  localparam logic [2:0] ALU_ADD      = 3'b000;
  localparam logic [2:0] ALU_OR       = 3'b010;

  typedef struct packed {
    logic       mem_req;
    logic       mem_out_write;
    logic       mem_write;
    logic       acc_write;
    logic       sp_write;
    logic       sign_ext;
    logic       pc_write;
    logic       ir_write;
    logic       sp_src;
    logic       branch_cycle;
    logic       mem_data;
    logic       out_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] acc_src;
    logic [1:0] branch_cond;
    logic [1:0] mem_addr;
    logic [2:0] alu_op;
  } ctrl_t;

  function automatic logic is_mem_state(state_e s);
    return s inside {S_FETCH, S_STORE, S_MEMRD, S_JAL, S_LWA2};
  endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// Counts consecutive not-ready cycles in a memory state; flags the cycle that
// would be the MAX_WAIT-th wait so the FSM can abort to HALT instead.
module ctrl_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic ready,
  output logic timeout
);

  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] LIMIT = CW'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

  logic [CW-1:0] cnt;

  assign timeout = (MAX_WAIT > 0) && active && !ready && (cnt == LIMIT);

  // Every memory state exits on ready, so clearing on ready also clears on entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                            cnt <= '0;
    else if (!active || ready || timeout)  cnt <= '0;
    else                                   cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/control_mc.sv
// Multicycle accumulator control FSM with memory handshake, wait timeout,
// illegal-opcode trap, HALT and a retired-instruction counter.
module control_mc
  import control_pkg::*;
#(
  parameter int INSTR_W         = 8,
  parameter int OPC_W           = 5,
  parameter int MAX_WAIT        = 15,
  parameter int TRAP_ON_ILLEGAL = 0,
  parameter int CNT_W           = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] opcode,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               MemOutWrite,
  output logic               MemWrite,
  output logic               ACCWrite,
  output logic               SPWrite,
  output logic               SignExt,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               SPSrc,
  output logic               BranchCycle,
  output logic               MemData,
  output logic               OutWrite,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSrc,
  output logic [1:0]         ACCSrc,
  output logic [1:0]         BranchCond,
  output logic [1:0]         MemAddr,
  output logic [2:0]         ALUOp,
  output logic               illegal,
  output logic               bus_error,
  output logic               halted,
  output logic [CNT_W-1:0]   instr_count
);

  localparam logic [OPC_W-1:0] OPC_HALT = '1;

  state_e           state;
  logic             ret_spc;
  logic             timeout;
  logic             unused_opcode;
  logic [OPC_W-1:0] opc;
  ctrl_t            c;

  assign opc           = opcode[OPC_W-1:0];
  assign unused_opcode = ^opcode;

  ctrl_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait (
    .clk     (clk),
    .reset   (reset),
    .active  (is_mem_state(state)),
    .ready   (mem_ready),
    .timeout (timeout)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_FETCH;
      ret_spc     <= 1'b0;
      illegal     <= 1'b0;
      bus_error   <= 1'b0;
      instr_count <= '0;
    end else if (timeout) begin
      state     <= S_HALT;
      bus_error <= 1'b1;
    end else begin
      case (state)
        S_FETCH: if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          ret_spc <= (opc == OPC_W'(OPC_SPC));
          case (opc)
            OPC_W'(OPC_ADDI):                  state <= S_ALUI;
            OPC_W'(OPC_SW):                    state <= S_STORE;
            OPC_W'(OPC_OR), OPC_W'(OPC_SPC):   state <= S_MEMRD;
            OPC_W'(OPC_JAL):                   state <= S_JAL;
            OPC_W'(OPC_BR):                    state <= S_BRANCH;
            OPC_W'(OPC_LWA):                   state <= S_LWA1;
            OPC_HALT:                          state <= S_HALT;
            default: begin
              state   <= S_ILLEGAL;
              illegal <= 1'b1;
            end
          endcase
        end
        S_ALUI, S_ALUM, S_BRANCH, S_SPC2: begin
          state       <= S_FETCH;
          instr_count <= instr_count + 1'b1;
        end
        S_STORE, S_JAL, S_LWA2: if (mem_ready) begin
          state       <= S_FETCH;
          instr_count <= instr_count + 1'b1;
        end
        S_MEMRD:   if (mem_ready) state <= ret_spc ? S_SPC2 : S_ALUM;
        S_LWA1:    state <= S_LWA2;
        S_ILLEGAL: state <= (TRAP_ON_ILLEGAL != 0) ? S_HALT : S_FETCH;
        S_HALT:    state <= S_HALT;
        default:   state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    c = '0;
    case (state)
      S_FETCH: begin
        c.mem_req   = 1'b1;
        c.mem_addr  = MEM_ADDR_PC;
        c.alu_src_a = ALU_A_PC;
        c.alu_src_b = ALU_B_ONE;
        c.alu_op    = ALU_ADD;
        c.pc_src    = PC_SRC_INC;
        c.ir_write  = mem_ready;
        c.pc_write  = mem_ready;
      end
      S_DECODE: begin
        c.alu_src_a = ALU_A_SP;
        c.alu_src_b = ALU_B_IMM;
        c.sign_ext  = 1'b1;
      end
      S_ALUI: begin
        c.acc_write = 1'b1;
        c.alu_src_a = ALU_A_ACC;
        c.alu_src_b = ALU_B_IR;
        c.sign_ext  = 1'b1;
        c.alu_op    = ALU_ADD;
        c.acc_src   = ACC_SRC_ALU;
      end
      S_STORE: begin
        c.mem_req   = 1'b1;
        c.mem_addr  = MEM_ADDR_ALU;
        c.mem_write = mem_ready;
      end
      S_MEMRD: begin
        c.mem_req       = 1'b1;
        c.mem_addr      = MEM_ADDR_ALU;
        c.mem_out_write = mem_ready;
      end
      S_ALUM: begin
        c.acc_write = 1'b1;
        c.alu_src_a = ALU_A_ACC;
        c.alu_src_b = ALU_B_MEM;
        c.acc_src   = ACC_SRC_ALU;
        c.alu_op    = ALU_OR;
      end
      S_JAL: begin
        c.mem_req   = 1'b1;
        c.mem_addr  = MEM_ADDR_SP;
        c.mem_data  = 1'b1;
        c.pc_src    = PC_SRC_ALUO;
        c.mem_write = mem_ready;
        c.pc_write  = mem_ready;
      end
      S_BRANCH: begin
        c.branch_cycle = 1'b1;
        c.pc_src       = PC_SRC_BR;
        c.branch_cond  = opcode[INSTR_W-1 -: 2];
      end
      S_SPC2: begin
        c.sp_write  = 1'b1;
        c.alu_src_a = ALU_A_SP;
        c.alu_src_b = ALU_B_MEM;
        c.alu_op    = ALU_ADD;
        c.sp_src    = 1'b1;
      end
      S_LWA1: begin
        c.alu_src_a = ALU_A_ACC;
        c.alu_src_b = ALU_B_IMM;
        c.sign_ext  = 1'b1;
      end
      S_LWA2: begin
        c.mem_req   = 1'b1;
        c.mem_addr  = MEM_ADDR_ALU;
        c.acc_src   = ACC_SRC_MEM;
        c.acc_write = mem_ready;
      end
      default: ;
    endcase
    // While held in reset the state reads FETCH; keep its selects but kill all side effects.
    if (!reset) begin
      c.mem_req       = 1'b0;
      c.mem_out_write = 1'b0;
      c.mem_write     = 1'b0;
      c.acc_write     = 1'b0;
      c.sp_write      = 1'b0;
      c.pc_write      = 1'b0;
      c.ir_write      = 1'b0;
      c.out_write     = 1'b0;
    end
  end

  assign mem_req     = c.mem_req;
  assign MemOutWrite = c.mem_out_write;
  assign MemWrite    = c.mem_write;
  assign ACCWrite    = c.acc_write;
  assign SPWrite     = c.sp_write;
  assign SignExt     = c.sign_ext;
  assign PCWrite     = c.pc_write;
  assign IRWrite     = c.ir_write;
  assign SPSrc       = c.sp_src;
  assign BranchCycle = c.branch_cycle;
  assign MemData     = c.mem_data;
  assign OutWrite    = c.out_write;
  assign ALUSrcA     = c.alu_src_a;
  assign ALUSrcB     = c.alu_src_b;
  assign PCSrc       = c.pc_src;
  assign ACCSrc      = c.acc_src;
  assign BranchCond  = c.branch_cond;
  assign MemAddr     = c.mem_addr;
  assign ALUOp       = c.alu_op;
  assign halted      = (state == S_HALT);

endmodule

// File: doc/control_mc.md
Name: control_mc

Overview:
Parametrised successor to the multicycle accumulator Control FSM. Same datapath control outputs and the same instruction flows, plus:
- a memory ready/request handshake with a wait-state timeout,
- illegal-opcode detection with a selectable trap,
- a HALT instruction,
- a retired-instruction counter.
Sits between the instruction register and the datapath/memory, replacing Control.

Parameters:
INSTR_W, 8, opcode input width
OPC_W, 5, width of opcode field opcode[OPC_W-1:0]; opcode[INSTR_W-1:INSTR_W-2] is the branch condition
MAX_WAIT, 15, max cycles in any memory state without mem_ready before bus error (0 = no timeout)
TRAP_ON_ILLEGAL, 0, 1 = illegal opcode enters HALT; 0 = skip it and fetch next
CNT_W, 16, width of instr_count

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
opcode  in  INSTR_W  current instruction register contents
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access requested in current state
MemOutWrite, MemWrite, ACCWrite, SPWrite, SignExt, PCWrite, IRWrite, SPSrc, BranchCycle, MemData, OutWrite  out  1  datapath controls, same meaning as Control
ALUSrcA, ALUSrcB, PCSrc, ACCSrc, BranchCond, MemAddr  out  2  datapath mux selects
ALUOp  out  3  ALU operation
illegal  out  1  sticky; an illegal opcode was decoded
bus_error  out  1  sticky; memory wait timed out
halted  out  1  FSM is in HALT
instr_count  out  CNT_W  instructions retired; wraps modulo 2^CNT_W

Behaviour:
- Moore FSM. Write enables in memory states are gated by mem_ready and drop to 0 while waiting.
- Unlisted outputs are 0 / 2'b00 / 3'b000 in every state.
- Reset asserted (low):
  - state = FETCH; every write enable and mem_req forced to 0.
  - Mux selects show FETCH values.
  - illegal = bus_error = 0; instr_count = 0.
- Reset released mid-access: access is abandoned; the FSM restarts at FETCH.
- FETCH: mem_req=1, MemAddr=00, ALUSrcA=00, ALUSrcB=10, ALUOp=000, PCSrc=01, IRWrite=PCWrite=mem_ready. Advances to DECODE on mem_ready.
- DECODE (1 cycle): ALUSrcA=01, ALUSrcB=01, SignExt=1. Dispatches on opc = opcode[OPC_W-1:0].
- opc 0 ADDI -> ALUI: ACCWrite=1, ALUSrcA=10, ALUSrcB=00, SignExt=1, ALUOp=000, ACCSrc=00 -> FETCH.
- opc 8 SW -> STORE: mem_req=1, MemAddr=01, MemData=0, MemWrite=mem_ready -> FETCH on ready.
- opc 11 OR -> MEMRD: mem_req=1, MemAddr=01, MemOutWrite=mem_ready -> ALUM on ready. ALUM: ACCWrite=1, ALUSrcA=10, ALUSrcB=11, ACCSrc=00, ALUOp=010 -> FETCH.
- opc 13 JAL -> JAL: mem_req=1, MemAddr=10, MemData=1, PCSrc=00, MemWrite=PCWrite=mem_ready -> FETCH on ready.
- opc 15 BR -> BRANCH: BranchCycle=1, PCSrc=10, BranchCond=opcode[INSTR_W-1:INSTR_W-2] -> FETCH.
- opc 22 SPC -> MEMRD (as OR) -> SPC2: SPWrite=1, ALUSrcA=01, ALUSrcB=11, ALUOp=000, SPSrc=1 -> FETCH. MEMRD records its return target in a 1-bit register.
- opc 23 LWA -> LWA1: ALUSrcA=10, ALUSrcB=01, SignExt=1 -> LWA2: mem_req=1, MemAddr=01, ACCSrc=10, ACCWrite=mem_ready -> FETCH on ready.
- opc 2^OPC_W-1 HALT -> HALT: halted=1, all enables 0. Leaves only via reset.
- Any other opc -> ILLEGAL (1 cycle): sets illegal. Then goes to HALT if TRAP_ON_ILLEGAL, else FETCH.
- Wait counter:
  - Cleared on entry to each memory state (FETCH, STORE, MEMRD, JAL, LWA2).
  - Increments each cycle with mem_ready=0.
  - If MAX_WAIT>0 and the counter reaches MAX_WAIT with mem_ready still 0: set bus_error and go to HALT; no write enable asserted that cycle.
  - mem_ready on the same cycle as the limit wins: normal completion.
- instr_count increments on the final cycle of each instruction, i.e. the transition into FETCH from any execute state. It does not increment for ILLEGAL or HALT. It wraps 2^CNT_W-1 -> 0.
- mem_ready outside memory states is ignored.

Decomposition:
- Shared package control_pkg: state enum, opcode constants (OPC_ADDI=0, OPC_SW=8, OPC_OR=11, OPC_JAL=13, OPC_BR=15, OPC_SPC=22, OPC_LWA=23), and mux-select constants (ALU_A_PC=00, ALU_A_SP=01, ALU_A_ACC=10, etc.).
- One sub-module, ctrl_wait_timer: wait counter plus timeout compare, parametrised by MAX_WAIT.

Test Plan:
1. mem_ready tied 1, opcode 0, reset pulse low -> FETCH: IRWrite=1, PCWrite=1, ALUSrcB=10, PCSrc=01. DECODE next, then ALUI with ACCWrite=1, ACCSrc=00. instr_count=1 on return to FETCH.
2. opcode 13, mem_ready low 3 cycles in JAL then high -> MemWrite=PCWrite=0 for 3 cycles, then 1 for one cycle with MemAddr=10, MemData=1; then FETCH.
3. opcode 8'h8F -> BRANCH with BranchCycle=1, PCSrc=10, BranchCond=2'b10. Repeat with opcode 75 -> MEMRD then ALUM with ALUOp=010.
4. MAX_WAIT=4, mem_ready held 0 in FETCH -> after 4 cycles bus_error=1, halted=1, IRWrite never asserted. Reset clears both.
5. opcode 5, TRAP_ON_ILLEGAL=0 -> illegal=1, FETCH next, instr_count unchanged. TRAP_ON_ILLEGAL=1 -> halted=1. opcode 31 -> halted=1 with illegal=0.
6. CNT_W=2, run 5 ADDIs -> instr_count 1,2,3,0,1. Reset asserted mid-LWA2 -> all enables 0 immediately, FETCH after release.
